pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port i_pmem_read  input  1  I-cache line-fill request, held until i_pmem_resp.
REQ-004 SHALL have port i_pmem_address  input  32  I-cache line address, 32-byte aligned.
REQ-005 SHALL have port i_pmem_rdata  output  256  fill data returned to the I-cache.
REQ-006 SHALL have port i_pmem_resp  output  1  single-cycle completion pulse to the I-cache.
REQ-007 SHALL have port d_pmem_read  input  1  D-cache fill request, held until d_pmem_resp.
REQ-008 SHALL have port d_pmem_write  input  1  D-cache writeback request, held until d_pmem_resp.
REQ-009 SHALL have port d_pmem_address  input  32  D-cache line address.
REQ-010 SHALL have port d_pmem_wdata  input  256  D-cache writeback line.
REQ-011 SHALL have port d_pmem_rdata  output  256  fill data returned to the D-cache.
REQ-012 SHALL have port d_pmem_resp  output  1  single-cycle completion pulse to the D-cache.
REQ-013 SHALL have ports mem_read and mem_write  output  1 each  shared-memory commands.
REQ-014 SHALL have ports mem_address  output  32, and mem_wdata  output  256  shared-memory address and write data.
REQ-015 SHALL have ports mem_rdata  input  256, and mem_resp  input  1  shared-memory read data and completion.

Function
REQ-016 SHALL implement the states IDLE, I_GNT and D_GNT, held in a registered state variable.
REQ-017 IDLE: SHALL drive all mem_* outputs to 0 and both *_resp outputs to 0.
REQ-018 IDLE with only an I-cache request SHALL go to I_GNT at the next edge.
REQ-019 IDLE with only a D-cache request (read or write) SHALL go to D_GNT at the next edge.
REQ-020 IDLE with both requesters active SHALL resolve the conflict per REQ-031/REQ-032.
REQ-021 Latency: a request first seen in IDLE at cycle n SHALL put the memory command on mem_* in cycle n+1.
REQ-022 I_GNT: mem_read=i_pmem_read, mem_write=0, mem_address=i_pmem_address; i_pmem_resp=mem_resp; i_pmem_rdata=mem_rdata.
REQ-023 D_GNT: mem_write=d_pmem_write, mem_read=d_pmem_read&~d_pmem_write, mem_address=d_pmem_address, mem_wdata=d_pmem_wdata.
REQ-024 D_GNT: d_pmem_resp=mem_resp and d_pmem_rdata=mem_rdata; if both d_pmem_read and d_pmem_write are asserted, the write SHALL win.
REQ-025 The non-granted requester's resp SHALL be 0; its rdata SHALL be 0.
REQ-026 A grant SHALL be held until mem_resp=1, then SHALL return to IDLE at the next edge; there is no back-to-back grant without an IDLE cycle.
REQ-027 A granted requester dropping its request before mem_resp SHALL NOT release the grant; mem_* follow the requester's lines.
REQ-028 mem_resp asserted while in IDLE SHALL be ignored.
REQ-029 The block SHALL track one bit last_gnt (0=I, 1=D), updated on entry to I_GNT/D_GNT.

Reset
REQ-030 While rst=0, state SHALL be IDLE, last_gnt SHALL be 1 (I-cache wins the first conflict), and all outputs SHALL be 0, asynchronously; reset mid-transaction SHALL abort the grant with no resp issued.

Configuration
REQ-031 With PMEM_ARB_RR_EN defined, a conflict in IDLE SHALL grant the requester opposite to last_gnt (round-robin).
REQ-032 With PMEM_ARB_RR_EN undefined, a conflict SHALL always grant the D-cache (fixed priority); last_gnt SHALL still be maintained but unused.

Structure
REQ-033 The state enum pmem_arb_state_t and the constant PMEM_LINE_WIDTH=256 SHALL reside in the shared package pmem_arb_types.
REQ-034 The block SHALL be a single module with no sub-module; the output muxing SHALL be combinational from the registered state.

Verification
REQ-035 Single I read at 0x0000_1000, mem_resp after 5 cycles -> mem_read=1 from cycle n+1, i_pmem_resp one pulse, i_pmem_rdata=mem_rdata, then IDLE.
REQ-036 D write to 0x0000_2020 with wdata=0xAA..AA -> mem_write=1, mem_wdata matches, d_pmem_resp one pulse, i_pmem_resp=0 throughout.
REQ-037 I and D requests in the same cycle after reset -> RR build: I first, then D; fixed build: D first, then I; each receives exactly one resp.
REQ-038 Both requesters held continuously for 4 transactions -> RR: grants alternate I,D,I,D; fixed: the D-cache is never starved.
REQ-039 rst pulsed low during D_GNT before mem_resp -> outputs are 0 immediately, state is IDLE, and no resp pulse occurs.
REQ-040 Spurious mem_resp in IDLE -> no resp to either requester and no state change.

Source files
------------

// File: rtl/pmem_arb_types.sv
// Shared types for the physical-memory arbiter: line width and arbiter state encoding.
package pmem_arb_types;

   localparam int PMEM_LINE_WIDTH = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_GNT = 2'd1,
      D_GNT = 2'd2
   } pmem_arb_state_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Two-port arbiter sharing one line-wide memory between the I-cache and the D-cache.
// Define PMEM_ARB_RR_EN for round-robin conflict resolution; otherwise the D-cache has fixed priority.
module pmem_arbiter
   import pmem_arb_types::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_pmem_read,
   input  logic [31:0]                i_pmem_address,
   output logic [PMEM_LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                       i_pmem_resp,
   input  logic                       d_pmem_read,
   input  logic                       d_pmem_write,
   input  logic [31:0]                d_pmem_address,
   input  logic [PMEM_LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [PMEM_LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                       d_pmem_resp,
   output logic                       mem_read,
   output logic                       mem_write,
   output logic [31:0]                mem_address,
   output logic [PMEM_LINE_WIDTH-1:0] mem_wdata,
   input  logic [PMEM_LINE_WIDTH-1:0] mem_rdata,
   input  logic                       mem_resp
);

   pmem_arb_state_t state_reg, state_next;
   logic            last_gnt_reg, last_gnt_next;   // 0 = I-cache, 1 = D-cache
   logic            i_req, d_req, pick_d;

   assign i_req = i_pmem_read;
   assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_RR_EN
   assign pick_d = ~last_gnt_reg;
`else
   assign pick_d = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         last_gnt_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         last_gnt_reg <= last_gnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      last_gnt_next = last_gnt_reg;
      case (state_reg)
         IDLE: begin
            if (i_req && d_req) begin
               state_next    = pick_d ? D_GNT : I_GNT;
               last_gnt_next = pick_d;
            end else if (d_req) begin
               state_next    = D_GNT;
               last_gnt_next = 1'b1;
            end else if (i_req) begin
               state_next    = I_GNT;
               last_gnt_next = 1'b0;
            end
         end
         // A grant is released only by the memory, never by the requester dropping its lines.
         I_GNT, D_GNT: begin
            if (mem_resp) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_address  = '0;
      mem_wdata    = '0;
      i_pmem_resp  = 1'b0;
      i_pmem_rdata = '0;
      d_pmem_resp  = 1'b0;
      d_pmem_rdata = '0;
      case (state_reg)
         I_GNT: begin
            mem_read     = i_pmem_read;
            mem_address  = i_pmem_address;
            i_pmem_resp  = mem_resp;
            i_pmem_rdata = mem_rdata;
         end
         D_GNT: begin
            mem_write    = d_pmem_write;
            mem_read     = d_pmem_read & ~d_pmem_write;
            mem_address  = d_pmem_address;
            mem_wdata    = d_pmem_wdata;
            d_pmem_resp  = mem_resp;
            d_pmem_rdata = mem_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed testbench for pmem_arbiter; expectations follow the build's PMEM_ARB_RR_EN setting.
module tb_pmem_arbiter;
   import pmem_arb_types::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i_pmem_read = 1'b0;
   logic [31:0]  i_pmem_address = '0;
   logic [255:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic         d_pmem_read = 1'b0;
   logic         d_pmem_write = 1'b0;
   logic [31:0]  d_pmem_address = '0;
   logic [255:0] d_pmem_wdata = '0;
   logic [255:0] d_pmem_rdata;
   logic         d_pmem_resp;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata = '0;
   logic         mem_resp = 1'b0;

   int vec_cnt = 0;
   int err_cnt = 0;

   localparam logic [255:0] PAT_A = {8{32'hAAAA_AAAA}};
   localparam logic [255:0] PAT_5 = {8{32'h5555_5555}};
   localparam logic [255:0] PAT_I = {8{32'h1234_5678}};
   localparam logic [255:0] PAT_D = {8{32'hCAFE_F00D}};

   pmem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_resp       (mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input pmem_arb_state_t exp);
      chk(tag, 256'(dut.state_reg), 256'(exp));
   endtask

   // Precondition: arbiter in IDLE with the request(s) already driven.
   // Resp arrives lat cycles after the grant cycle.
   task automatic run_txn(input string tag, input pmem_arb_state_t g, input logic ex_rd,
                          input logic ex_wr, input logic [31:0] ex_addr, input int lat,
                          input logic [255:0] rd, input logic drop);
      tick();
      chk_state({tag, "_gnt"}, g);
      chk({tag, "_mrd"}, 256'(mem_read), 256'(ex_rd));
      chk({tag, "_mwr"}, 256'(mem_write), 256'(ex_wr));
      chk({tag, "_maddr"}, 256'(mem_address), 256'(ex_addr));
      chk({tag, "_iresp0"}, 256'(i_pmem_resp), 256'(1'b0));
      chk({tag, "_dresp0"}, 256'(d_pmem_resp), 256'(1'b0));
      for (int k = 1; k < lat; k++) begin
         tick();
         chk({tag, "_wait_iresp"}, 256'(i_pmem_resp), 256'(1'b0));
         chk({tag, "_wait_dresp"}, 256'(d_pmem_resp), 256'(1'b0));
      end
      tick();
      mem_resp  = 1'b1;
      mem_rdata = rd;
      #1;
      if (g == I_GNT) begin
         chk({tag, "_iresp"}, 256'(i_pmem_resp), 256'(1'b1));
         chk({tag, "_irdata"}, i_pmem_rdata, rd);
         chk({tag, "_dresp_off"}, 256'(d_pmem_resp), 256'(1'b0));
         chk({tag, "_drdata_off"}, d_pmem_rdata, 256'(0));
      end else begin
         chk({tag, "_dresp"}, 256'(d_pmem_resp), 256'(1'b1));
         chk({tag, "_drdata"}, d_pmem_rdata, rd);
         chk({tag, "_iresp_off"}, 256'(i_pmem_resp), 256'(1'b0));
         chk({tag, "_irdata_off"}, i_pmem_rdata, 256'(0));
      end
      tick();
      mem_resp  = 1'b0;
      mem_rdata = '0;
      if (drop) begin
         if (g == I_GNT) i_pmem_read = 1'b0;
         else begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
         end
      end
      #1;
      chk_state({tag, "_idle"}, IDLE);
      chk({tag, "_iresp_end"}, 256'(i_pmem_resp), 256'(1'b0));
      chk({tag, "_dresp_end"}, 256'(d_pmem_resp), 256'(1'b0));
      $display("txn %s: grant %s, resp after %0d cycles", tag, g.name(), lat);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pmem_arb_state_t first_g, second_g;
      logic            last_exp;

      // Reset with a live memory response on the bus: nothing may leak through.
      #2 rst = 1'b0;
      mem_resp  = 1'b1;
      mem_rdata = PAT_I;
      #1;
      chk_state("rst_state", IDLE);
      chk("rst_last_gnt", 256'(dut.last_gnt_reg), 256'(1'b1));
      chk("rst_mem_read", 256'(mem_read), 256'(1'b0));
      chk("rst_mem_write", 256'(mem_write), 256'(1'b0));
      chk("rst_mem_addr", 256'(mem_address), 256'(0));
      chk("rst_mem_wdata", mem_wdata, 256'(0));
      chk("rst_iresp", 256'(i_pmem_resp), 256'(1'b0));
      chk("rst_dresp", 256'(d_pmem_resp), 256'(1'b0));
      chk("rst_irdata", i_pmem_rdata, 256'(0));
      chk("rst_drdata", d_pmem_rdata, 256'(0));
      tick();
      tick();
      mem_resp  = 1'b0;
      mem_rdata = '0;
      rst = 1'b1;
      tick();

      // Simultaneous I and D requests straight after reset.
      i_pmem_read    = 1'b1;
      i_pmem_address = 32'h0000_1000;
      d_pmem_read    = 1'b1;
      d_pmem_address = 32'h0000_2000;
      #1;
      chk("conf_idle_mrd", 256'(mem_read), 256'(1'b0));
`ifdef PMEM_ARB_RR_EN
      first_g  = I_GNT;
      second_g = D_GNT;
      last_exp = 1'b1;
`else
      first_g  = D_GNT;
      second_g = I_GNT;
      last_exp = 1'b0;
`endif
      run_txn("conf1", first_g, 1'b1, 1'b0, (first_g == I_GNT) ? 32'h0000_1000 : 32'h0000_2000,
              3, (first_g == I_GNT) ? PAT_I : PAT_D, 1'b1);
      run_txn("conf2", second_g, 1'b1, 1'b0, (second_g == I_GNT) ? 32'h0000_1000 : 32'h0000_2000,
              2, (second_g == I_GNT) ? PAT_I : PAT_D, 1'b1);
      chk("conf_last_gnt", 256'(dut.last_gnt_reg), 256'(last_exp));
      tick();

      // Single I-cache read: command one cycle after the request, resp 5 cycles after the request.
      i_pmem_read    = 1'b1;
      i_pmem_address = 32'h0000_1000;
      #1;
      chk("iread_n_mrd", 256'(mem_read), 256'(1'b0));
      run_txn("iread", I_GNT, 1'b1, 1'b0, 32'h0000_1000, 4, PAT_5, 1'b1);
      chk("iread_last_gnt", 256'(dut.last_gnt_reg), 256'(1'b0));
      tick();

      // D-cache writeback.
      d_pmem_write   = 1'b1;
      d_pmem_address = 32'h0000_2020;
      d_pmem_wdata   = PAT_A;
      @(posedge clk);
      #1;
      chk_state("dwr_gnt", D_GNT);
      chk("dwr_wdata", mem_wdata, PAT_A);
      chk("dwr_mrd", 256'(mem_read), 256'(1'b0));
      chk("dwr_mwr", 256'(mem_write), 256'(1'b1));
      chk("dwr_addr", 256'(mem_address), 256'(32'h0000_2020));
      mem_resp = 1'b1;
      #1;
      chk("dwr_dresp", 256'(d_pmem_resp), 256'(1'b1));
      chk("dwr_iresp", 256'(i_pmem_resp), 256'(1'b0));
      tick();
      mem_resp     = 1'b0;
      d_pmem_write = 1'b0;
      #1;
      chk_state("dwr_idle", IDLE);
      chk("dwr_dresp_end", 256'(d_pmem_resp), 256'(1'b0));
      $display("txn dwr: grant D_GNT write 0x00002020");

      // Read+write together: write wins; dropping lines mid-grant keeps the grant.
      d_pmem_read    = 1'b1;
      d_pmem_write   = 1'b1;
      d_pmem_address = 32'h0000_2040;
      d_pmem_wdata   = PAT_5;
      tick();
      chk_state("rw_gnt", D_GNT);
      chk("rw_mwr", 256'(mem_write), 256'(1'b1));
      chk("rw_mrd", 256'(mem_read), 256'(1'b0));
      d_pmem_write = 1'b0;
      #1;
      chk("rw_follow_mrd", 256'(mem_read), 256'(1'b1));
      chk("rw_follow_mwr", 256'(mem_write), 256'(1'b0));
      d_pmem_read = 1'b0;
      tick();
      chk_state("rw_hold", D_GNT);
      chk("rw_drop_mrd", 256'(mem_read), 256'(1'b0));
      mem_resp = 1'b1;
      #1;
      chk("rw_dresp", 256'(d_pmem_resp), 256'(1'b1));
      tick();
      mem_resp = 1'b0;
      #1;
      chk_state("rw_idle", IDLE);
      $display("txn rw: grant D_GNT held after request drop");

      // Reset pulse during a D grant before the memory answers.
      d_pmem_read    = 1'b1;
      d_pmem_address = 32'h0000_3000;
      tick();
      chk_state("rstmid_gnt", D_GNT);
      chk("rstmid_mrd", 256'(mem_read), 256'(1'b1));
      #2;
      rst      = 1'b0;
      mem_resp = 1'b1;
      #1;
      chk_state("rstmid_state", IDLE);
      chk("rstmid_mrd0", 256'(mem_read), 256'(1'b0));
      chk("rstmid_addr0", 256'(mem_address), 256'(0));
      chk("rstmid_dresp", 256'(d_pmem_resp), 256'(1'b0));
      chk("rstmid_last_gnt", 256'(dut.last_gnt_reg), 256'(1'b1));
      tick();
      chk("rstmid_dresp2", 256'(d_pmem_resp), 256'(1'b0));
      d_pmem_read = 1'b0;
      mem_resp    = 1'b0;
      rst         = 1'b1;
      tick();
      chk_state("rstmid_after", IDLE);
      $display("txn rstmid: D_GNT aborted by reset");

      // Both requesters held continuously for four transactions.
      i_pmem_read    = 1'b1;
      i_pmem_address = 32'h0000_4000;
      d_pmem_read    = 1'b1;
      d_pmem_address = 32'h0000_5000;
      for (int t = 0; t < 4; t++) begin
         pmem_arb_state_t g;
`ifdef PMEM_ARB_RR_EN
         g = (t % 2 == 0) ? I_GNT : D_GNT;
`else
         g = D_GNT;
`endif
         run_txn($sformatf("hold%0d", t), g, 1'b1, 1'b0,
                 (g == I_GNT) ? 32'h0000_4000 : 32'h0000_5000, 1 + t,
                 (g == I_GNT) ? PAT_I : PAT_D, 1'b0);
      end
      i_pmem_read = 1'b0;
      d_pmem_read = 1'b0;
      tick();

      // Spurious memory response while idle.
      mem_resp  = 1'b1;
      mem_rdata = PAT_A;
      #1;
      chk("spur_iresp", 256'(i_pmem_resp), 256'(1'b0));
      chk("spur_dresp", 256'(d_pmem_resp), 256'(1'b0));
      chk("spur_irdata", i_pmem_rdata, 256'(0));
      tick();
      chk_state("spur_state1", IDLE);
      tick();
      chk_state("spur_state2", IDLE);
      chk("spur_dresp2", 256'(d_pmem_resp), 256'(1'b0));
      mem_resp  = 1'b0;
      mem_rdata = '0;
      $display("txn spur: mem_resp ignored in IDLE");

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
